pe_feeder: RTL and testbench

Sequencer that drives one 3-tap MAC processing element (PE) for a 1-D convolution row. On `start` it reads three kernel weights and then a row of features from two synchronous read memories. It shifts these into the PE via `W_w`/`W_in` and `IF_w`/`IF_in`, captures the PE's combinational `Result` once three features are resident, and writes each result to an output memory port. It is the transmitter/consumer counterpart of the PE in the convolution datapath.

---
 rtl/pe_pkg.sv | 21 ++
 rtl/pe_feeder_if.sv | 54 +++++
 rtl/pe_feed_addr_gen.sv | 46 ++++
 rtl/pe_feeder.sv | 182 ++++++++++++++++++
 tb/tb_pe_feeder.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared definitions for the PE feeder: default widths, kernel tap count and
// the sequencer state encoding.
package pe_pkg;

   localparam int DEF_DATA_BITS     = 16;
   localparam int DEF_INTERNAL_BITS = 32;
   localparam int DEF_ADDR_BITS     = 10;
   localparam int DEF_LEN_BITS      = 10;

   // Taps in the processing element; also the minimum useful row length.
   localparam int KERNEL_TAPS = 3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      LOAD_F,
      DRAIN,
      DONE
   } feeder_state_e;

endpackage

// File: rtl/pe_feeder_if.sv
// Bus bundle between the feeder and its surroundings: weight memory read
// port, feature memory read port, PE shift/result port and output write port.
// master = the feeder, slave = memories + PE + output memory.
interface pe_feeder_if
   import pe_pkg::*;
#(
   parameter int DATA_BITS     = DEF_DATA_BITS,
   parameter int INTERNAL_BITS = DEF_INTERNAL_BITS,
   parameter int ADDR_BITS     = DEF_ADDR_BITS
);

   // Weight memory read port
   logic                            w_rd;
   logic        [ADDR_BITS-1:0]     w_addr;
   logic signed [DATA_BITS-1:0]     w_rdata;

   // Feature memory read port
   logic                            if_rd;
   logic        [ADDR_BITS-1:0]     if_addr;
   logic signed [DATA_BITS-1:0]     if_rdata;

   // PE shift inputs and combinational dot product
   logic                            W_w;
   logic signed [DATA_BITS-1:0]     W_in;
   logic                            IF_w;
   logic signed [DATA_BITS-1:0]     IF_in;
   logic signed [INTERNAL_BITS-1:0] Result;

   // Output memory write port
   logic                            o_we;
   logic        [ADDR_BITS-1:0]     o_addr;
   logic signed [INTERNAL_BITS-1:0] o_data;

   modport master (
      output w_rd, w_addr,
      input  w_rdata,
      output if_rd, if_addr,
      input  if_rdata,
      output W_w, W_in, IF_w, IF_in,
      input  Result,
      output o_we, o_addr, o_data
   );

   modport slave (
      input  w_rd, w_addr,
      output w_rdata,
      input  if_rd, if_addr,
      output if_rdata,
      input  W_w, W_in, IF_w, IF_in,
      output Result,
      input  o_we, o_addr, o_data
   );

endinterface

// File: rtl/pe_feed_addr_gen.sv
// Loadable base+offset address counter. The address wraps modulo
// 2^ADDR_BITS; tc is high while the offset equals the loaded last offset.
module pe_feed_addr_gen
   import pe_pkg::*;
#(
   parameter int ADDR_BITS = DEF_ADDR_BITS,
   parameter int LEN_BITS  = DEF_LEN_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [ADDR_BITS-1:0] base,
   input  logic [LEN_BITS-1:0]  last_off,
   input  logic                 inc,
   output logic [ADDR_BITS-1:0] addr,
   output logic                 tc
);

   localparam logic [LEN_BITS-1:0] OFF_ONE = LEN_BITS'(1);

   logic [ADDR_BITS-1:0] base_q;
   logic [LEN_BITS-1:0]  off_q;
   logic [LEN_BITS-1:0]  last_q;

   // Base/offset registers: load restarts the offset at zero, inc advances it.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge (synchronous, active-low) and
      // all state uses non-blocking assignments so every register sees the
      // pre-edge values of its neighbours.
      if (!rst) begin
         base_q <= '0;
         off_q  <= '0;
         last_q <= '0;
      end else if (load) begin
         base_q <= base;
         off_q  <= '0;
         last_q <= last_off;
      end else if (inc) begin
         off_q  <= off_q + OFF_ONE;
      end
   end

   assign addr = base_q + ADDR_BITS'(off_q);
   assign tc   = (off_q == last_q);

endmodule

// File: rtl/pe_feeder.sv
// Sequencer feeding one 3-tap MAC PE for a 1-D convolution row.
// Reads three weights then N features, shifts them into the PE, captures the
// PE result once three fresh features are resident and writes N-2 outputs.
// Build option: define PE_FEEDER_RELU_EN to clamp negative results to zero
// before they are registered; timing is the same either way.
module pe_feeder
   import pe_pkg::*;
#(
   parameter int DATA_BITS     = DEF_DATA_BITS,
   parameter int INTERNAL_BITS = DEF_INTERNAL_BITS,
   parameter int ADDR_BITS     = DEF_ADDR_BITS,
   parameter int LEN_BITS      = DEF_LEN_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [LEN_BITS-1:0]  row_len,
   input  logic [ADDR_BITS-1:0] w_base,
   input  logic [ADDR_BITS-1:0] if_base,
   input  logic [ADDR_BITS-1:0] o_base,
   output logic                 busy,
   output logic                 done,
   pe_feeder_if.master          bus
);

   localparam logic [LEN_BITS-1:0] LEN_ONE    = LEN_BITS'(1);
   localparam logic [LEN_BITS-1:0] TAPS_LAST  = LEN_BITS'(KERNEL_TAPS - 1);
   localparam logic [LEN_BITS-1:0] TAPS_COUNT = LEN_BITS'(KERNEL_TAPS);

   feeder_state_e state, state_nxt;

   logic ld;
   logic w_inc, w_tc;
   logic f_inc, f_tc;
   logic long_job;

   logic                            if_w_d1;
   logic [LEN_BITS-1:0]             cap_cnt;
   logic [LEN_BITS-1:0]             len_q;
   logic [ADDR_BITS-1:0]            o_base_q;
   logic                            o_last;
   logic signed [INTERNAL_BITS-1:0] res_val;
   logic signed [DATA_BITS-1:0]     w_data, f_data;

   assign long_job = (row_len >= TAPS_COUNT);

   // Memory read data goes straight into the PE shift inputs; the shift
   // strobes below are the read requests delayed to line up with the data.
   assign w_data     = bus.w_rdata;
   assign f_data     = bus.if_rdata;
   assign bus.W_in   = w_data;
   assign bus.IF_in  = f_data;

`ifdef PE_FEEDER_RELU_EN
   assign res_val = bus.Result[INTERNAL_BITS-1] ? '0 : bus.Result;
`else
   assign res_val = bus.Result;
`endif

   pe_feed_addr_gen #(
      .ADDR_BITS (ADDR_BITS),
      .LEN_BITS  (LEN_BITS)
   ) u_w_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .base     (w_base),
      .last_off (TAPS_LAST),
      .inc      (w_inc),
      .addr     (bus.w_addr),
      .tc       (w_tc)
   );

   pe_feed_addr_gen #(
      .ADDR_BITS (ADDR_BITS),
      .LEN_BITS  (LEN_BITS)
   ) u_f_gen (
      .clk      (clk),
      .rst      (rst),
      .load     (ld),
      .base     (if_base),
      .last_off (row_len - LEN_ONE),
      .inc      (f_inc),
      .addr     (bus.if_addr),
      .tc       (f_tc)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state and control outputs. DONE hands straight back to IDLE, but
   // also samples start so a new job can be accepted in the done cycle.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no branch
      // can leave one unassigned and infer a latch.
      state_nxt  = state;
      ld         = 1'b0;
      w_inc      = 1'b0;
      f_inc      = 1'b0;
      bus.w_rd   = 1'b0;
      bus.if_rd  = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE, DONE: begin
            done = (state == DONE);
            if (start) begin
               ld        = long_job;
               state_nxt = long_job ? LOAD_W : DONE;
            end else begin
               state_nxt = IDLE;
            end
         end
         LOAD_W: begin
            busy     = 1'b1;
            bus.w_rd = 1'b1;
            w_inc    = 1'b1;
            if (w_tc) state_nxt = LOAD_F;
         end
         LOAD_F: begin
            busy      = 1'b1;
            bus.if_rd = 1'b1;
            f_inc     = 1'b1;
            if (f_tc) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (bus.o_we && o_last) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Shift strobes: one-cycle delayed read requests, plus a second delay of
   // the feature strobe that marks the cycle the PE result is settled.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.W_w  <= 1'b0;
         bus.IF_w <= 1'b0;
         if_w_d1  <= 1'b0;
      end else begin
         bus.W_w  <= bus.w_rd;
         bus.IF_w <= bus.if_rd;
         if_w_d1  <= bus.IF_w;
      end
   end

   // Result capture: cap_cnt is the index of the feature just shifted in;
   // from the third feature on, the PE holds a full window and its result
   // becomes output cap_cnt-2.
   always_ff @(posedge clk) begin
      if (!rst) begin
         cap_cnt    <= '0;
         len_q      <= '0;
         o_base_q   <= '0;
         o_last     <= 1'b0;
         bus.o_we   <= 1'b0;
         bus.o_addr <= '0;
         bus.o_data <= '0;
      end else begin
         bus.o_we <= 1'b0;
         o_last   <= 1'b0;
         if (ld) begin
            cap_cnt  <= '0;
            len_q    <= row_len;
            o_base_q <= o_base;
         end else if (if_w_d1) begin
            cap_cnt <= cap_cnt + LEN_ONE;
            if (cap_cnt >= TAPS_LAST) begin
               bus.o_we   <= 1'b1;
               bus.o_addr <= o_base_q + ADDR_BITS'(cap_cnt - TAPS_LAST);
               bus.o_data <= res_val;
               o_last     <= (cap_cnt == len_q - LEN_ONE);
            end
         end
      end
   end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder: synchronous read memories and a
// behavioural 3-tap PE surround the DUT; expected writes come from the
// convolution sum out[j] = sum_i k[i]*x[j+i] computed directly on arrays.
module tb_pe_feeder;
   import pe_pkg::*;

   localparam int DB    = DEF_DATA_BITS;
   localparam int IB    = DEF_INTERNAL_BITS;
   localparam int AB    = DEF_ADDR_BITS;
   localparam int LB    = DEF_LEN_BITS;
   localparam int DEPTH = 1 << AB;
   localparam int AMASK = DEPTH - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [LB-1:0] row_len = '0;
   logic [AB-1:0] w_base = '0;
   logic [AB-1:0] if_base = '0;
   logic [AB-1:0] o_base = '0;
   logic          busy;
   logic          done;

   pe_feeder_if #(.DATA_BITS(DB), .INTERNAL_BITS(IB), .ADDR_BITS(AB)) bus ();

   pe_feeder #(
      .DATA_BITS     (DB),
      .INTERNAL_BITS (IB),
      .ADDR_BITS     (AB),
      .LEN_BITS      (LB)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .row_len (row_len),
      .w_base  (w_base),
      .if_base (if_base),
      .o_base  (o_base),
      .busy    (busy),
      .done    (done),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- environment: memories and PE ----------------
   logic signed [DB-1:0] wmem [DEPTH];
   logic signed [DB-1:0] fmem [DEPTH];

   always @(posedge clk) begin
      if (!rst) begin
         bus.w_rdata  <= '0;
         bus.if_rdata <= '0;
      end else begin
         if (bus.w_rd)  bus.w_rdata  <= wmem[bus.w_addr];
         if (bus.if_rd) bus.if_rdata <= fmem[bus.if_addr];
      end
   end

   logic signed [DB-1:0] pw0 = '0, pw1 = '0, pw2 = '0;
   logic signed [DB-1:0] pf0 = '0, pf1 = '0, pf2 = '0;

   always @(posedge clk) begin
      if (bus.W_w) begin
         pw2 <= pw1; pw1 <= pw0; pw0 <= bus.W_in;
      end
      if (bus.IF_w) begin
         pf2 <= pf1; pf1 <= pf0; pf0 <= bus.IF_in;
      end
   end

   always_comb
      bus.Result = IB'(int'(pw0) * int'(pf0) + int'(pw1) * int'(pf1) + int'(pw2) * int'(pf2));

   // ---------------- monitor ----------------
   typedef struct {
      int rel;
      int addr;
      int data;
   } ev_t;

   ev_t wr_q[$];
   ev_t wrd_q[$];
   ev_t ifrd_q[$];
   int  done_q[$];
   int  busy_cnt, busy_first, busy_last;
   bit  mon_en = 1'b0;
   int  t0 = 0;

   always @(negedge clk) begin
      ev_t e;
      if (mon_en) begin
         e.rel = cyc - t0;
         if (bus.o_we) begin
            e.addr = int'(bus.o_addr); e.data = int'(bus.o_data);
            wr_q.push_back(e);
         end
         if (bus.w_rd) begin
            e.addr = int'(bus.w_addr); e.data = 0;
            wrd_q.push_back(e);
         end
         if (bus.if_rd) begin
            e.addr = int'(bus.if_addr); e.data = 0;
            ifrd_q.push_back(e);
         end
         if (done) done_q.push_back(e.rel);
         if (busy) begin
            if (busy_cnt == 0) busy_first = e.rel;
            busy_last = e.rel;
            busy_cnt++;
         end
      end
   end

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   int kq[3];
   int xq[$];

   function automatic int ref_out(input int j);
      int acc = 0;
      for (int i = 0; i < KERNEL_TAPS; i++) acc += kq[i] * xq[j + i];
`ifdef PE_FEEDER_RELU_EN
      if (acc < 0) acc = 0;
`endif
      return acc;
   endfunction

   task automatic setup_mem(input int wb, input int ib);
      for (int i = 0; i < KERNEL_TAPS; i++) wmem[(wb + i) & AMASK] = DB'(kq[i]);
      for (int i = 0; i < xq.size(); i++) fmem[(ib + i) & AMASK] = DB'(xq[i]);
   endtask

   // Called just after a rising edge; the current cycle becomes cycle 0.
   task automatic launch(input int n, input int wb, input int ib, input int ob);
      wr_q.delete(); wrd_q.delete(); ifrd_q.delete(); done_q.delete();
      busy_cnt = 0; busy_first = -1; busy_last = -1;
      row_len = LB'(n);
      w_base  = AB'(wb);
      if_base = AB'(ib);
      o_base  = AB'(ob);
      start   = 1'b1;
      t0      = cyc;
      mon_en  = 1'b1;
   endtask

   task automatic run_job(input int n, input int wb, input int ib, input int ob, input bit hold);
      bit seen = 1'b0;
      setup_mem(wb, ib);
      @(posedge clk); #1;
      launch(n, wb, ib, ob);
      for (int i = 0; i < n + 40 && !seen; i++) begin
         @(posedge clk); #1;
         if (i == 0 && !hold) start = 1'b0;
         if (done) begin
            seen  = 1'b1;
            start = 1'b0;
         end
      end
      check($sformatf("done_seen_n%0d", n), seen, 1);
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_job(input string nm, input int n, input int wb, input int ib, input int ob);
      int ew, er, ef;
      er = (n >= KERNEL_TAPS) ? KERNEL_TAPS : 0;
      ef = (n >= KERNEL_TAPS) ? n : 0;
      ew = (n >= KERNEL_TAPS) ? n - 2 : 0;
      check({nm, "_w_rd_count"}, wrd_q.size(), er);
      for (int i = 0; i < wrd_q.size() && i < er; i++) begin
         check($sformatf("%s_w_rd%0d_cycle", nm, i), wrd_q[i].rel, i + 1);
         check($sformatf("%s_w_rd%0d_addr", nm, i), wrd_q[i].addr, (wb + i) & AMASK);
      end
      check({nm, "_if_rd_count"}, ifrd_q.size(), ef);
      for (int i = 0; i < ifrd_q.size() && i < ef; i++) begin
         check($sformatf("%s_if_rd%0d_cycle", nm, i), ifrd_q[i].rel, i + 4);
         check($sformatf("%s_if_rd%0d_addr", nm, i), ifrd_q[i].addr, (ib + i) & AMASK);
      end
      check({nm, "_write_count"}, wr_q.size(), ew);
      for (int j = 0; j < wr_q.size() && j < ew; j++) begin
         check($sformatf("%s_wr%0d_cycle", nm, j), wr_q[j].rel, j + 9);
         check($sformatf("%s_wr%0d_addr", nm, j), wr_q[j].addr, (ob + j) & AMASK);
         check($sformatf("%s_wr%0d_data", nm, j), wr_q[j].data, ref_out(j));
      end
      check({nm, "_done_count"}, done_q.size(), 1);
      if (done_q.size() > 0)
         check({nm, "_done_cycle"}, done_q[0], (n >= KERNEL_TAPS) ? n + 7 : 1);
      check({nm, "_busy_cycles"}, busy_cnt, (n >= KERNEL_TAPS) ? n + 6 : 0);
      if (n >= KERNEL_TAPS) begin
         check({nm, "_busy_first"}, busy_first, 1);
         check({nm, "_busy_last"}, busy_last, n + 6);
      end
   endtask

   task automatic check_outputs_zero(input string nm);
      check({nm, "_busy"},    busy, 0);
      check({nm, "_done"},    done, 0);
      check({nm, "_w_rd"},    bus.w_rd, 0);
      check({nm, "_if_rd"},   bus.if_rd, 0);
      check({nm, "_W_w"},     bus.W_w, 0);
      check({nm, "_IF_w"},    bus.IF_w, 0);
      check({nm, "_o_we"},    bus.o_we, 0);
      check({nm, "_w_addr"},  bus.w_addr, 0);
      check({nm, "_if_addr"}, bus.if_addr, 0);
      check({nm, "_o_addr"},  bus.o_addr, 0);
      check({nm, "_o_data"},  bus.o_data, 0);
   endtask

   task automatic randomize_job(input int n);
      logic signed [DB-1:0] r;
      for (int i = 0; i < KERNEL_TAPS; i++) begin
         r = DB'($urandom);
         kq[i] = int'(r);
      end
      xq.delete();
      for (int i = 0; i < n; i++) begin
         r = DB'($urandom);
         xq.push_back(int'(r));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      int n, wb, ib, ob;

      // Reset state
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b1;

      // Basic row: k = [1,2,3], x = 1..8
      kq = '{1, 2, 3};
      xq.delete();
      for (int i = 1; i <= 8; i++) xq.push_back(i);
      run_job(8, 10, 100, 200, 1'b0);
      check_job("basic", 8, 10, 100, 200);
      if (wr_q.size() == 6) begin
         check("basic_first_value", wr_q[0].data, 14);
         check("basic_last_value", wr_q[5].data, 44);
      end

      // Negative results (clamped when the ReLU build is selected)
      kq = '{-1, 0, 1};
      xq = '{5, 3, 1, 0};
      run_job(4, 20, 300, 400, 1'b0);
      check_job("neg", 4, 20, 300, 400);
      if (wr_q.size() == 2) begin
`ifdef PE_FEEDER_RELU_EN
         check("neg_value0", wr_q[0].data, 0);
         check("neg_value1", wr_q[1].data, 0);
`else
         check("neg_value0", wr_q[0].data, -4);
         check("neg_value1", wr_q[1].data, -3);
`endif
      end

      // Short rows: no memory traffic, done the cycle after start
      kq = '{7, 7, 7};
      xq = '{1, 2};
      run_job(2, 30, 500, 600, 1'b0);
      check_job("short2", 2, 30, 500, 600);
      xq.delete();
      run_job(0, 30, 500, 600, 1'b0);
      check_job("short0", 0, 30, 500, 600);

      // start held for the whole job: exactly one job
      randomize_job(5);
      run_job(5, 40, 700, 800, 1'b1);
      check_job("held", 5, 40, 700, 800);

      // Reset in cycle 6 of an N=8 job aborts it
      randomize_job(8);
      setup_mem(50, 120);
      @(posedge clk); #1;
      launch(8, 50, 120, 220);
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < t0 + 6) begin
         @(posedge clk); #1;
      end
      rst = 1'b0;
      @(posedge clk); #1;
      check_outputs_zero("abort");
      rst = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("abort_done_count", done_q.size(), 0);
      check("abort_write_count", wr_q.size(), 0);
      check("abort_w_rd_count", wrd_q.size(), 3);
      check("abort_if_rd_count", ifrd_q.size(), 3);

      // Clean job after the abort
      randomize_job(8);
      run_job(8, 50, 120, 220, 1'b0);
      check_job("after_abort", 8, 50, 120, 220);

      // Feature and output address wrap-around
      randomize_job(4);
      run_job(4, 60, DEPTH - 2, DEPTH - 1, 1'b0);
      check_job("wrap", 4, 60, DEPTH - 2, DEPTH - 1);
      if (ifrd_q.size() == 4) begin
         check("wrap_if_addr2", ifrd_q[2].addr, 0);
         check("wrap_if_addr3", ifrd_q[3].addr, 1);
      end

      // Random rows
      for (int t = 0; t < 5; t++) begin
         n  = $urandom_range(3, 24);
         wb = $urandom_range(0, DEPTH - 1);
         ib = $urandom_range(0, DEPTH - 1);
         ob = $urandom_range(0, DEPTH - 1);
         randomize_job(n);
         run_job(n, wb, ib, ob, 1'b0);
         check_job($sformatf("rand%0d", t), n, wb, ib, ob);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
